// File: rtl/lab2_proc_int_mul_iter.sv
// Iterative shift-add 32x32 multiplier returning the low 32 bits of the product (RISC-V MUL).
// One multiplier bit per cycle; optionally stops once the remaining multiplier bits are zero.
module lab2_proc_int_mul_iter #(
  parameter bit p_early_exit = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [63:0] req_msg,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_msg,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        last_iter;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // Exit on the iteration that consumes the last set multiplier bit, or the 32nd iteration.
  assign last_iter = (cnt_q == 6'd31) || (p_early_exit && ((b_q >> 1) == 32'd0));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_val) begin
          a_d      = req_msg[63:32];
          b_d      = req_msg[31:0];
          result_d = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (b_q[0]) begin
          result_d = result_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 6'd1;
        if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (resp_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // req_rdy is masked by reset so it reads low while reset is held.
  assign req_rdy  = reset && (state_q == StIdle);
  assign resp_val = (state_q == StDone);
  assign busy     = (state_q == StCalc) || (state_q == StDone);
  assign resp_msg = result_q;

endmodule

// File: tb/tb_lab2_proc_int_mul_iter.sv
// Bench for the iterative multiplier: two instances (early exit on/off) checked every cycle
// against a transaction-level model, plus directed cases with hand-computed results.
module tb_lab2_proc_int_mul_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val  [2];
  logic        req_rdy  [2];
  logic [63:0] req_msg  [2];
  logic        resp_val [2];
  logic        resp_rdy [2];
  logic [31:0] resp_msg [2];
  logic        busy     [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lab2_proc_int_mul_iter #(.p_early_exit(1'b1)) u_ee (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val[0]),
    .req_rdy  (req_rdy[0]),
    .req_msg  (req_msg[0]),
    .resp_val (resp_val[0]),
    .resp_rdy (resp_rdy[0]),
    .resp_msg (resp_msg[0]),
    .busy     (busy[0])
  );

  lab2_proc_int_mul_iter #(.p_early_exit(1'b0)) u_fix (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val[1]),
    .req_rdy  (req_rdy[1]),
    .req_msg  (req_msg[1]),
    .resp_val (resp_val[1]),
    .resp_rdy (resp_rdy[1]),
    .resp_msg (resp_msg[1]),
    .busy     (busy[1])
  );

  function automatic logic [31:0] mul_lo(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  // Cycles spent computing: 32 without early exit, else position of b's top set bit (min 1).
  function automatic int k_of(input int idx, input logic [31:0] b);
    if (idx == 1) return 32;
    for (int i = 31; i >= 1; i--) begin
      if (b[i]) return i + 1;
    end
    return 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: 0 = waiting for request, 1 = computing, 2 = holding response.
  int          m_phase [2];
  int          m_left  [2];
  logic [31:0] m_prod  [2];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_phase[i] <= 0;
        m_left[i]  <= 0;
        m_prod[i]  <= '0;
      end else begin
        case (m_phase[i])
          0: if (req_val[i]) begin
            m_prod[i]  <= mul_lo(req_msg[i][63:32], req_msg[i][31:0]);
            m_left[i]  <= k_of(i, req_msg[i][31:0]);
            m_phase[i] <= 1;
          end
          1: begin
            m_left[i] <= m_left[i] - 1;
            if (m_left[i] == 1) m_phase[i] <= 2;
          end
          2: if (resp_rdy[i]) m_phase[i] <= 0;
          default: m_phase[i] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d req_rdy", i), {31'd0, req_rdy[i]},
            {31'd0, (reset === 1'b1) && (m_phase[i] == 0)});
      check($sformatf("u%0d resp_val", i), {31'd0, resp_val[i]}, {31'd0, m_phase[i] == 2});
      check($sformatf("u%0d busy", i), {31'd0, busy[i]}, {31'd0, m_phase[i] != 0});
      if (m_phase[i] == 2) check($sformatf("u%0d resp_msg", i), resp_msg[i], m_prod[i]);
    end
  end

  task automatic txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_k, input int hold, input bit noise);
    int n;
    n = 0;
    while (req_rdy[idx] !== 1'b1 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check($sformatf("u%0d ready for request", idx), {31'd0, req_rdy[idx]}, 32'd1);
    req_val[idx] = 1'b1;
    req_msg[idx] = {a, b};
    @(posedge clk); #2;
    req_val[idx] = 1'b0;
    req_msg[idx] = {$urandom, $urandom};
    n = 1;
    while (resp_val[idx] !== 1'b1 && n < 64) begin
      if (noise) begin
        req_val[idx] = 1'($urandom_range(0, 1));
        req_msg[idx] = {$urandom, $urandom};
      end
      @(posedge clk); #2;
      n++;
    end
    req_val[idx] = 1'b0;
    check($sformatf("u%0d latency b=0x%08h", idx, b), n, exp_k + 1);
    check($sformatf("u%0d result a=0x%08h b=0x%08h", idx, a, b), resp_msg[idx], exp);
    for (int h = 0; h < hold; h++) begin
      check($sformatf("u%0d held resp_val", idx), {31'd0, resp_val[idx]}, 32'd1);
      check($sformatf("u%0d held req_rdy", idx), {31'd0, req_rdy[idx]}, 32'd0);
      check($sformatf("u%0d held resp_msg", idx), resp_msg[idx], exp);
      req_val[idx] = (h == hold / 2);
      req_msg[idx] = {$urandom, $urandom};
      @(posedge clk); #2;
    end
    req_val[idx]  = 1'b0;
    resp_rdy[idx] = 1'b1;
    @(posedge clk); #2;
    resp_rdy[idx] = 1'b0;
    check($sformatf("u%0d req_rdy after resp", idx), {31'd0, req_rdy[idx]}, 32'd1);
    check($sformatf("u%0d resp_val after resp", idx), {31'd0, resp_val[idx]}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_val[i]  = 1'b0;
      req_msg[i]  = '0;
      resp_rdy[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d reset req_rdy", i), {31'd0, req_rdy[i]}, 32'd0);
      check($sformatf("u%0d reset resp_val", i), {31'd0, resp_val[i]}, 32'd0);
      check($sformatf("u%0d reset busy", i), {31'd0, busy[i]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("u0 req_rdy after reset", {31'd0, req_rdy[0]}, 32'd1);

    // Directed cases with hand-computed results and latencies.
    txn(0, 32'd3, 32'd5, 32'd15, 3, 0, 0);
    txn(0, 32'hDEADBEEF, 32'd0, 32'd0, 1, 0, 0);
    txn(0, 32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 1, 0, 0);
    txn(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 0, 0);
    txn(0, 32'h80000000, 32'd2, 32'd0, 2, 0, 0);
    txn(1, 32'd7, 32'd6, 32'd42, 32, 0, 0);
    txn(0, 32'd1234, 32'd5678, 32'd7006652, 13, 10, 0);
    txn(0, 32'd11, 32'd13, 32'd143, 4, 0, 0);

    // Reset in the middle of CALC drops the operation.
    req_val[0] = 1'b1;
    req_msg[0] = {32'd9, 32'h0000FFFF};
    @(posedge clk); #2;
    req_val[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid-op reset resp_val", {31'd0, resp_val[0]}, 32'd0);
    check("mid-op reset busy", {31'd0, busy[0]}, 32'd0);
    check("mid-op reset req_rdy", {31'd0, req_rdy[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("req_rdy after mid-op reset", {31'd0, req_rdy[0]}, 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      check("no response after reset", {31'd0, resp_val[0]}, 32'd0);
    end
    txn(0, 32'd2, 32'd3, 32'd6, 2, 0, 0);

    // Randomized traffic on both instances.
    for (int r = 0; r < 40; r++) begin
      for (int idx = 0; idx < 2; idx++) begin
        a = $urandom;
        b = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) b = 32'($urandom_range(0, 1));
        txn(idx, a, b, mul_lo(a, b), k_of(idx, b), $urandom_range(0, 3), 1'b1);
      end
    end

    @(posedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
